// File: rtl/ppu_sprite_tile_eval_if.sv
// Bus between the sprite tile evaluator and its controller/OAM side:
// scan request, OAM read port and the two-slot sprite result.
interface ppu_sprite_tile_eval_if;
  logic       start;
  logic [8:0] curr_row;
  logic [8:0] curr_col;
  logic [7:0] ppu_ctrl1;
  logic [7:0] ppu_ctrl2;
  logic [7:0] oam_addr;
  logic [7:0] oam_data_in;
  logic       sprite_0_on_tile;
  logic [7:0] sprite_0_tile_num;
  logic [7:0] sprite_0_row;
  logic [7:0] sprite_0_col;
  logic [7:0] sprite_0_attr;
  logic       sprite_1_on_tile;
  logic [7:0] sprite_1_tile_num;
  logic [7:0] sprite_1_row;
  logic [7:0] sprite_1_col;
  logic [7:0] sprite_1_attr;
  logic       sprite_overflow;
  logic       busy;
  logic       done;

  modport master (
    output start, curr_row, curr_col, ppu_ctrl1, ppu_ctrl2, oam_data_in,
    input  oam_addr,
    input  sprite_0_on_tile, sprite_0_tile_num, sprite_0_row, sprite_0_col, sprite_0_attr,
    input  sprite_1_on_tile, sprite_1_tile_num, sprite_1_row, sprite_1_col, sprite_1_attr,
    input  sprite_overflow, busy, done
  );

  modport slave (
    input  start, curr_row, curr_col, ppu_ctrl1, ppu_ctrl2, oam_data_in,
    output oam_addr,
    output sprite_0_on_tile, sprite_0_tile_num, sprite_0_row, sprite_0_col, sprite_0_attr,
    output sprite_1_on_tile, sprite_1_tile_num, sprite_1_row, sprite_1_col, sprite_1_attr,
    output sprite_overflow, busy, done
  );
endinterface

// File: rtl/ppu_sprite_tile_eval.sv
// Scans OAM for the first two sprites covering an 8-pixel tile span and
// publishes them (plus an overflow flag) to the VRAM load FSM.
module ppu_sprite_tile_eval #(
  parameter int unsigned NUM_SPRITES = 64
) (
  input logic                  clk,
  input logic                  rst,
  ppu_sprite_tile_eval_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_SPRITES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_T, S_Y, S_T, S_A, S_X, S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [8:0]    row_q;
  logic [8:0]    col_q;
  logic          tall_q;
  logic [7:0]    cur_y, cur_t, cur_a;

  logic          sh_on0, sh_on1, sh_ovf;
  logic [7:0]    sh_t0, sh_r0, sh_c0, sh_a0;
  logic [7:0]    sh_t1, sh_r1, sh_c1, sh_a1;

  logic [8:0]    row_diff;
  logic [9:0]    col_diff;
  logic          row_hit, col_hit, last;
  logic [IW-1:0] idx_nx;

  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{bus.ppu_ctrl1[7:6], bus.ppu_ctrl1[4:0],
                              bus.ppu_ctrl2[7:5], bus.ppu_ctrl2[3:0]};

  always_comb begin
    row_diff = row_q - {1'b0, bus.oam_data_in};
    row_hit  = !row_q[8] && (row_q >= {1'b0, bus.oam_data_in}) &&
               (row_diff < (tall_q ? 9'd16 : 9'd8));
    col_diff = {2'b00, bus.oam_data_in} - {col_q[8], col_q};
    col_hit  = ($signed(col_diff) >= -10'sd7) && ($signed(col_diff) <= 10'sd7);
    last     = (idx == IW'(NUM_SPRITES - 1));
    idx_nx   = idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tall_q   <= 1'b0;
      cur_y    <= '0;
      cur_t    <= '0;
      cur_a    <= '0;
      {sh_on0, sh_t0, sh_r0, sh_c0, sh_a0} <= '0;
      {sh_on1, sh_t1, sh_r1, sh_c1, sh_a1} <= '0;
      sh_ovf   <= 1'b0;
      bus.oam_addr          <= '0;
      bus.sprite_0_on_tile  <= 1'b0;
      bus.sprite_0_tile_num <= '0;
      bus.sprite_0_row      <= '0;
      bus.sprite_0_col      <= '0;
      bus.sprite_0_attr     <= '0;
      bus.sprite_1_on_tile  <= 1'b0;
      bus.sprite_1_tile_num <= '0;
      bus.sprite_1_row      <= '0;
      bus.sprite_1_col      <= '0;
      bus.sprite_1_attr     <= '0;
      bus.sprite_overflow   <= 1'b0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            row_q    <= bus.curr_row;
            col_q    <= bus.curr_col;
            tall_q   <= bus.ppu_ctrl1[5];
            {sh_on0, sh_t0, sh_r0, sh_c0, sh_a0} <= '0;
            {sh_on1, sh_t1, sh_r1, sh_c1, sh_a1} <= '0;
            sh_ovf   <= 1'b0;
            if (!bus.ppu_ctrl2[4]) begin
              state <= S_DONE;
            end else begin
              idx          <= '0;
              bus.oam_addr <= '0;
              state        <= S_ADDR_T;
            end
          end
        end
        S_ADDR_T: begin
          bus.oam_addr <= 8'({idx, 2'b01});
          state        <= S_Y;
        end
        S_Y: begin
          cur_y <= bus.oam_data_in;
          if (row_hit) begin
            bus.oam_addr <= 8'({idx, 2'b10});
            state        <= S_T;
          end else if (last) begin
            state <= S_DONE;
          end else begin
            idx          <= idx_nx;
            bus.oam_addr <= 8'({idx_nx, 2'b00});
            state        <= S_ADDR_T;
          end
        end
        S_T: begin
          cur_t        <= bus.oam_data_in;
          bus.oam_addr <= 8'({idx, 2'b11});
          state        <= S_A;
        end
        S_A: begin
          // Prefetch the next y here so S_X can jump straight to S_Y: a
          // row-hit then costs 4 clocks instead of 5.
          cur_a <= bus.oam_data_in;
          if (!last) bus.oam_addr <= 8'({idx_nx, 2'b00});
          state <= S_X;
        end
        S_X: begin
          if (col_hit && !sh_on0) begin
            {sh_on0, sh_t0, sh_r0, sh_c0, sh_a0} <= {1'b1, cur_t, cur_y, bus.oam_data_in, cur_a};
          end else if (col_hit && !sh_on1) begin
            {sh_on1, sh_t1, sh_r1, sh_c1, sh_a1} <= {1'b1, cur_t, cur_y, bus.oam_data_in, cur_a};
          end
          if (col_hit && sh_on0 && sh_on1) begin
            sh_ovf <= 1'b1;
            state  <= S_DONE;
          end else if (last) begin
            state <= S_DONE;
          end else begin
            idx          <= idx_nx;
            bus.oam_addr <= 8'({idx_nx, 2'b01});
            state        <= S_Y;
          end
        end
        S_DONE: begin
          bus.sprite_0_on_tile  <= sh_on0;
          bus.sprite_0_tile_num <= sh_t0;
          bus.sprite_0_row      <= sh_r0;
          bus.sprite_0_col      <= sh_c0;
          bus.sprite_0_attr     <= sh_a0;
          bus.sprite_1_on_tile  <= sh_on1;
          bus.sprite_1_tile_num <= sh_t1;
          bus.sprite_1_row      <= sh_r1;
          bus.sprite_1_col      <= sh_c1;
          bus.sprite_1_attr     <= sh_a1;
          bus.sprite_overflow   <= sh_ovf;
          bus.done              <= 1'b1;
          bus.busy              <= 1'b0;
          state                 <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_sprite_tile_eval.sv
// Directed scans against a synchronous-read OAM model; expected results are
// queued per scan and checked by a monitor on each done pulse.
module tb_ppu_sprite_tile_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppu_sprite_tile_eval_if bus();

  ppu_sprite_tile_eval #(.NUM_SPRITES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] oam [256];
  always @(posedge clk) bus.oam_data_in <= oam[bus.oam_addr];

  typedef struct {
    logic [66:0] res;
    int          lat_min;
    int          lat_max;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          dones = 0;
  int          max_addr = 0;
  logic [66:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [66:0] mk(
    input logic on0, input logic [7:0] t0, r0, c0, a0,
    input logic on1, input logic [7:0] t1, r1, c1, a1, input logic ovf);
    return {on0, t0, r0, c0, a0, on1, t1, r1, c1, a1, ovf};
  endfunction

  function automatic logic [66:0] act_res();
    return {bus.sprite_0_on_tile, bus.sprite_0_tile_num, bus.sprite_0_row,
            bus.sprite_0_col, bus.sprite_0_attr,
            bus.sprite_1_on_tile, bus.sprite_1_tile_num, bus.sprite_1_row,
            bus.sprite_1_col, bus.sprite_1_attr, bus.sprite_overflow};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse; between pulses the
  // published results must stay at the last committed value.
  always @(negedge clk) begin
    if (rst) begin
      held = '0;
    end else begin
      if (bus.busy && int'(bus.oam_addr) > max_addr) max_addr = int'(bus.oam_addr);
      if (bus.done) begin
        dones++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
        end else begin
          exp_t e;
          int   lat;
          e   = q.pop_front();
          lat = cyc - start_cyc;
          if (act_res() !== e.res) begin
            fails++;
            $display("FAIL scan_result: got %h expected %h", act_res(), e.res);
          end
          tests++;
          if (lat < e.lat_min || lat > e.lat_max) begin
            fails++;
            $display("FAIL done_latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
          end
          held = e.res;
        end
      end else if (bus.busy) begin
        tests++;
        if (act_res() !== held) begin
          fails++;
          $display("FAIL hold_during_scan: got %h expected %h", act_res(), held);
        end
      end
    end
  end

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) begin
      oam[4*i]   = 8'hFF;
      oam[4*i+1] = 8'h00;
      oam[4*i+2] = 8'h00;
      oam[4*i+3] = 8'h00;
    end
  endtask

  task automatic set_spr(input int idx, input logic [7:0] y, t, a, x);
    oam[4*idx]   = y;
    oam[4*idx+1] = t;
    oam[4*idx+2] = a;
    oam[4*idx+3] = x;
  endtask

  task automatic run_scan(input logic [8:0] row, col, input logic [7:0] c1, c2,
                          input logic [66:0] res, input int lmin, lmax, input int inject);
    exp_t e;
    int   d0;
    int   n;
    e.res = res; e.lat_min = lmin; e.lat_max = lmax;
    q.push_back(e);
    d0 = dones;
    max_addr = 0;
    @(negedge clk);
    bus.curr_row = row; bus.curr_col = col;
    bus.ppu_ctrl1 = c1; bus.ppu_ctrl2 = c2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    if (inject > 0) begin
      repeat (inject) @(negedge clk);
      bus.curr_row = 9'd0; bus.ppu_ctrl2 = 8'h00;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (dones == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (dones == d0) begin
      tests++;
      fails++;
      $display("FAIL scan_timeout: got no done after %0d cycles expected done", n);
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.curr_row = '0; bus.curr_col = '0;
    bus.ppu_ctrl1 = '0; bus.ppu_ctrl2 = '0;
    clear_oam();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {act_res(), bus.busy, bus.done, bus.oam_addr},
        {67'b0, 1'b0, 1'b0, 8'h00});

    // Full miss scan with an ignored start pulse mid-scan.
    run_scan(9'd10, 9'd0, 8'h00, 8'h10, '0, 129, 129, 20);

    set_spr(5, 8'd10, 8'h33, 8'h41, 8'd20);
    run_scan(9'd12, 9'd16, 8'h00, 8'h10,
             mk(1, 8'h33, 8'd10, 8'd20, 8'h41, 0, 0, 0, 0, 0, 0), 131, 131, 0);

    clear_oam();
    set_spr(2,  8'd38, 8'h12, 8'h02, 8'd64);
    set_spr(4,  8'd40, 8'h14, 8'h04, 8'd80);
    set_spr(7,  8'd35, 8'h17, 8'h07, 8'd60);
    set_spr(9,  8'd33, 8'h19, 8'h09, 8'd70);
    set_spr(12, 8'd40, 8'h1C, 8'h0C, 8'd64);
    run_scan(9'd40, 9'd64, 8'h00, 8'h10,
             mk(1, 8'h12, 8'd38, 8'd64, 8'h02, 1, 8'h17, 8'd35, 8'd60, 8'h07, 1), 1, 200, 0);
    tests++;
    if (max_addr > 40) begin
      fails++;
      $display("FAIL overflow_stop_addr: got max oam_addr %0d expected <= 40", max_addr);
    end

    clear_oam();
    set_spr(0, 8'd10, 8'h55, 8'h20, 8'd100);
    run_scan(9'd24, 9'd100, 8'h20, 8'h10,
             mk(1, 8'h55, 8'd10, 8'd100, 8'h20, 0, 0, 0, 0, 0, 0), 1, 200, 0);
    run_scan(9'd24, 9'd100, 8'h00, 8'h10, '0, 1, 200, 0);

    clear_oam();
    set_spr(3, 8'd50, 8'hA3, 8'h13, 8'd2);
    set_spr(4, 8'd50, 8'hA4, 8'h14, 8'd4);
    set_spr(6, 8'd45, 8'hA6, 8'h16, 8'd0);
    run_scan(9'd50, 9'h1FC, 8'h00, 8'h10,
             mk(1, 8'hA3, 8'd50, 8'd2, 8'h13, 1, 8'hA6, 8'd45, 8'd0, 8'h16, 0), 1, 200, 0);

    // Sprites enabled off: no scan even though OAM holds hits.
    run_scan(9'd50, 9'h1FC, 8'h00, 8'h00, '0, 1, 2, 0);

    clear_oam();
    set_spr(3, 8'd50, 8'hB3, 8'h23, 8'hF9);
    run_scan(9'd50, 9'h100, 8'h00, 8'h10, '0, 1, 200, 0);

    clear_oam();
    set_spr(5, 8'd10, 8'h33, 8'h41, 8'd20);
    run_scan(9'd12, 9'd16, 8'h00, 8'h10,
             mk(1, 8'h33, 8'd10, 8'd20, 8'h41, 0, 0, 0, 0, 0, 0), 131, 131, 0);

    // Abort a scan with reset.
    @(negedge clk);
    bus.curr_row = 9'd12; bus.curr_col = 9'd16;
    bus.ppu_ctrl1 = 8'h00; bus.ppu_ctrl2 = 8'h10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    d0 = dones;
    #2 rst = 1'b1;
    #1 chk("reset_abort_outputs", {act_res(), bus.busy, bus.done, bus.oam_addr},
           {67'b0, 1'b0, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("reset_abort_no_done", 67'(dones), 67'(d0));

    run_scan(9'd12, 9'd16, 8'h00, 8'h10,
             mk(1, 8'h33, 8'd10, 8'd20, 8'h41, 0, 0, 0, 0, 0, 0), 131, 131, 0);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
